// File: rtl/intersect_pixel_shader.sv
// Purpose: turns per-pixel intersection results into RGB444 frame-buffer writes (palette lookup, optional depth shading, linear address).
// Latency: valid_in sampled at edge N is pushed into the output FIFO at edge N+2 and presented after that edge; 1 pixel/cycle sustained.
// Backpressure: fb_ready_in stalls the FIFO only; upstream cannot be stalled, so a push into a full FIFO is dropped and overflow_out sticks.
// Optional build: define SHADE_DEPTH_EN to attenuate hit colours by the float32 exponent of best_t.

module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // A full FIFO still accepts a push when the head retires in the same cycle.
  assign out_vld = (count != '0);
  assign in_rdy  = (count != FULL_CNT) || out_rdy;
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;
  assign out_dat = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= in_dat;
  end
endmodule

module intersect_pixel_shader #(
  parameter int          H_RES          = 1024,
  parameter int          V_RES          = 768,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          SHADE_EXP_BASE = 137,
  parameter logic [11:0] BG_COLOR       = 12'h000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic [3:0]  best_block,
  input  logic [31:0] best_t,
  input  logic        fb_ready_in,
  output logic        fb_valid_out,
  output logic [19:0] fb_addr_out,
  output logic [11:0] fb_data_out,
  output logic        frame_done_out,
  output logic        overflow_out
);
  typedef struct packed {
    logic [19:0] addr;
    logic [11:0] rgb;
  } fb_word_t;

  localparam logic [19:0] H_STRIDE  = 20'(H_RES);
  localparam logic [19:0] LAST_ADDR = 20'(H_RES * V_RES - 1);

  logic        hit;
  logic [11:0] pal;
  logic [11:0] pix_color;
  logic        qualify;

  logic        s1_vld;
  logic [10:0] s1_x;
  logic [9:0]  s1_y;
  logic [11:0] s1_rgb;

  logic        s2_vld;
  fb_word_t    s2_word;

  logic        fifo_in_rdy;
  fb_word_t    head_word;

`ifdef SHADE_DEPTH_EN
  localparam logic [7:0] SHADE_BASE = 8'(SHADE_EXP_BASE);
  logic [7:0] exp_diff;
  logic [1:0] shift;
  logic       unused_t_bits;
  assign unused_t_bits = ^best_t[22:0];
`else
  localparam int unused_shade_base = SHADE_EXP_BASE;
  logic unused_t_bits;
  assign unused_t_bits = ^best_t[30:0];
`endif

  assign qualify = valid_in && ({1'b0, x_in} < 12'(H_RES)) && ({1'b0, y_in} < 11'(V_RES));

  // Palette lookup and optional exponent-based attenuation; misses and negative t get the background.
  always_comb begin
    pal = BG_COLOR;
    hit = (best_block <= 4'd11) && !best_t[31];
    case (best_block)
      4'd0:    pal = 12'hF00;
      4'd1:    pal = 12'h0F0;
      4'd2:    pal = 12'h00F;
      4'd3:    pal = 12'hFF0;
      4'd4:    pal = 12'h0FF;
      4'd5:    pal = 12'hF0F;
      4'd6:    pal = 12'hFFF;
      4'd7:    pal = 12'hF80;
      4'd8:    pal = 12'h8F0;
      4'd9:    pal = 12'h08F;
      4'd10:   pal = 12'hF08;
      4'd11:   pal = 12'h888;
      default: pal = BG_COLOR;
    endcase
`ifdef SHADE_DEPTH_EN
    exp_diff = 8'd0;
    shift    = 2'd0;
    if (best_t[30:23] > SHADE_BASE) begin
      exp_diff = best_t[30:23] - SHADE_BASE;
      shift    = (exp_diff >= 8'd3) ? 2'd3 : exp_diff[1:0];
    end
    pix_color = hit ? {pal[11:8] >> shift, pal[7:4] >> shift, pal[3:0] >> shift} : BG_COLOR;
`else
    pix_color = hit ? pal : BG_COLOR;
`endif
  end

  // Stage 1: capture coordinates and colour; out-of-range pixels never become valid.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      s1_vld <= 1'b0;
      s1_x   <= '0;
      s1_y   <= '0;
      s1_rgb <= '0;
    end else begin
      s1_vld <= qualify;
      s1_x   <= x_in;
      s1_y   <= y_in;
      s1_rgb <= pix_color;
    end
  end

  // Stage 2: linear address; in-range coordinates cannot overflow 20 bits.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      s2_vld  <= 1'b0;
      s2_word <= '0;
    end else begin
      s2_vld       <= s1_vld;
      s2_word.addr <= 20'(s1_y) * H_STRIDE + 20'(s1_x);
      s2_word.rgb  <= s1_rgb;
    end
  end

  sync_fifo #(
    .W     ($bits(fb_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk_in),
    .rst_n   (rst_in),
    .in_vld  (s2_vld),
    .in_dat  (s2_word),
    .in_rdy  (fifo_in_rdy),
    .out_vld (fb_valid_out),
    .out_dat (head_word),
    .out_rdy (fb_ready_in)
  );

  // Outputs read zero whenever no write is being offered.
  assign fb_addr_out = fb_valid_out ? head_word.addr : '0;
  assign fb_data_out = fb_valid_out ? head_word.rgb  : '0;

  // Sticky drop flag: only a push refused by a full FIFO sets it.
  always_ff @(posedge clk_in) begin
    if (!rst_in)                        overflow_out <= 1'b0;
    else if (s2_vld && !fifo_in_rdy)    overflow_out <= 1'b1;
  end

  // One-cycle pulse after the last pixel of the frame is handed off.
  always_ff @(posedge clk_in) begin
    if (!rst_in) frame_done_out <= 1'b0;
    else         frame_done_out <= fb_valid_out && fb_ready_in && (head_word.addr == LAST_ADDR);
  end
endmodule
